smpc_intback_engine: RTL and testbench
======================================

Name: smpc_intback_engine

Overview:
- Parametrised INTBACK sequencer for the SMPC command engine.
- Builds the status block and peripheral reports for NUM_PORTS pads, and streams them into the OREG file one byte per CE tick.
- When a report overflows OREG_DEPTH, it splits into fragments using the CONTINUE/BREAK handshake, and signals each fragment with MIRQ_N.
- Sits between the COMREG/IREG decode and the OREG register file.

Parameters:
- NUM_PORTS, 2, number of peripheral ports scanned (1..8).
- OREG_DEPTH, 32, OREG bytes per fragment (8..64).
- IRQ_CYCLES, 4, CE ticks MIRQ_N is held low per fragment.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset.
- CE  in  1  clock enable; all sequencing advances only when CE=1.
- START  in  1  one-CLK strobe: INTBACK command accepted.
- IREG0  in  8  bit0 = status request.
- IREG1  in  8  bit3 = peripheral request.
- STAT  in  128  status block bytes 0..15; byte0 = STAT[127:120].
- CONT  in  1  one-CLK strobe: host CONTINUE.
- BRK  in  1  one-CLK strobe: host BREAK.
- PCONN  in  NUM_PORTS  per-port connected flag.
- JOY  in  16*NUM_PORTS  pad data; port i = JOY[16i+15:16i].
- OREG_WE  out  1  OREG write strobe.
- OREG_ADDR  out  $clog2(OREG_DEPTH)  write address.
- OREG_DATA  out  8  write data.
- SR_HI  out  3  SR[7:5].
- SF_CLR  out  1  one-CLK pulse: clear SF.
- MIRQ_N  out  1  interrupt to master CPU, active low.
- BUSY  out  1  sequence in progress.

Behaviour:
- Reset: RST_N is asynchronous, active-low; clock CLK. Reset values:
  - OREG_WE=0, OREG_ADDR=0, OREG_DATA=0.
  - SR_HI=000, SF_CLR=0, MIRQ_N=1, BUSY=0.
  - State IDLE; port index 0; write pointer 0.
  - Reset mid-sequence aborts immediately; no further writes.
- States: IDLE, STATUS, PERIPH, PAD, IRQ, WAIT_HS, DONE.
- IDLE:
  - START=1 -> BUSY=1, pointer=0.
  - Goes to STATUS if IREG0[0]=1, else PERIPH if IREG1[3]=1, else DONE.
  - START while BUSY is ignored.
- STATUS:
  - Writes STAT bytes 0..15 to addresses 0..15, one per CE tick.
  - Then -> PAD, with SR_HI={0,1,IREG1[3]}.
  - If IREG1[3]=1, peripheral data follows in a later fragment.
- PERIPH:
  - Connected port record: F1, 02, JOY[hi], JOY[lo] (4 bytes).
  - Unconnected port record: F0 (1 byte).
  - Records never straddle a fragment. If the remaining space is smaller than the next record, go to PAD with SR_HI=111 (more data).
  - After the last port -> PAD with SR_HI=110.
- PAD: see optional feature. Then -> IRQ.
- IRQ:
  - MIRQ_N=0 for exactly IRQ_CYCLES CE ticks, then returns to 1.
  - SR_HI bit5=1 (more data) or a pending peripheral phase -> WAIT_HS.
  - Otherwise -> DONE.
- WAIT_HS:
  - CONT -> pointer=0, resume PERIPH at the saved port index.
  - BRK -> SR_HI=000, -> DONE.
  - CONT and BRK in the same cycle: BRK wins.
  - CONT/BRK outside WAIT_HS are ignored.
  - No timeout.
- DONE: SF_CLR=1 for one CLK, BUSY=0, -> IDLE.
- OREG_ADDR wraps never: the pointer saturates at OREG_DEPTH-1 and the write at the full boundary is suppressed.
- Latency: first OREG_WE on the first CE tick after the CLK edge that samples START.
- JOY/PCONN are sampled per port when that port's first byte is written.

Optional Feature:
- Macro: SMPC_OREG_PAD_EN.
- Defined: PAD writes 0x00 to every address from the pointer to OREG_DEPTH-1 before IRQ, one per CE tick.
- Undefined: PAD takes zero ticks; unwritten OREG bytes keep stale contents.

Test Plan:
- NUM_PORTS=2, PCONN=11, JOY0=FFF7, JOY1=1234, IREG0=01, IREG1=08, START -> fragment 1:
  - STAT to 0..15, SR_HI=011, MIRQ_N low 4 ticks.
  - After CONT: F1 02 FF F7 F1 02 12 34 at 0..7, SR_HI=110, then SF_CLR pulse.
- PCONN=01 with peripheral only (IREG0=00, IREG1=08) -> F1 02 JOY0 F0 at 0..4, SR_HI=110, a single IRQ.
- NUM_PORTS=8, OREG_DEPTH=8, all connected -> four fragments of 8 bytes, each with SR_HI=111 except the last (110).
- BRK asserted in WAIT_HS together with CONT -> SR_HI=000, no further OREG_WE, SF_CLR pulse, BUSY=0.
- With SMPC_OREG_PAD_EN, single port unconnected -> F0 at 0, then 0x00 written to 1..31 before MIRQ_N falls.
- RST_N asserted mid-PERIPH -> all outputs at reset values immediately; a later START runs a full clean sequence.

Source files
------------

// File: rtl/smpc_intback_engine.sv
// INTBACK sequencer: streams the SMPC status block and per-port peripheral reports into OREG,
// fragmenting through CONTINUE/BREAK. Define SMPC_OREG_PAD_EN to zero-fill OREG before each IRQ.
module smpc_intback_engine #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned OREG_DEPTH = 32,
  parameter int unsigned IRQ_CYCLES = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          i_ce,
  input  logic                          i_start,
  input  logic [7:0]                    i_ireg0,
  input  logic [7:0]                    i_ireg1,
  input  logic [127:0]                  i_stat,
  input  logic                          i_cont,
  input  logic                          i_brk,
  input  logic [NUM_PORTS-1:0]          i_pconn,
  input  logic [16*NUM_PORTS-1:0]       i_joy,
  output logic                          o_oreg_we,
  output logic [$clog2(OREG_DEPTH)-1:0] o_oreg_addr,
  output logic [7:0]                    o_oreg_data,
  output logic [2:0]                    o_sr_hi,
  output logic                          o_sf_clr,
  output logic                          o_mirq_n,
  output logic                          o_busy
);
  localparam int unsigned AW  = $clog2(OREG_DEPTH);
  localparam int unsigned PIW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW  = $clog2(IRQ_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STATUS, S_PERIPH, S_PAD, S_IRQ, S_WAIT_HS, S_DONE
  } state_t;

  state_t          r_state, w_state_nx;
  logic [AW-1:0]   r_ptr, w_ptr_nx;
  logic            r_full, w_full_nx;
  logic [3:0]      r_sidx, w_sidx_nx;
  logic [PIW-1:0]  r_port, w_port_nx;
  logic [1:0]      r_byte, w_byte_nx;
  logic [15:0]     r_joy, w_joy_nx;
  logic            r_preq, w_preq_nx;
  logic            r_pend, w_pend_nx;
  logic [CW-1:0]   r_irq_cnt, w_irq_cnt_nx;
  logic            r_oreg_we, w_we_nx;
  logic [AW-1:0]   r_oreg_addr, w_addr_nx;
  logic [7:0]      r_oreg_data, w_data_nx;
  logic [2:0]      r_sr_hi, w_sr_hi_nx;
  logic            r_sf_clr, w_sf_clr_nx;
  logic            r_mirq_n, w_mirq_n_nx;
  logic            r_busy, w_busy_nx;

  logic [15:0]     w_joy_sel;
  logic            w_conn_sel;
  logic [7:0]      w_stat_byte;
  logic [AW:0]     w_space;
  logic [AW:0]     w_need;
  logic            w_wr;
  logic [7:0]      w_wr_byte;
  logic            w_port_done;
  logic            w_unused;

  assign w_unused = ^{i_ireg0[7:1], i_ireg1[7:4], i_ireg1[2:0]};

  // Current-port and current-status-byte selection.
  always_comb begin
    w_joy_sel   = 16'h0000;
    w_conn_sel  = 1'b0;
    w_stat_byte = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_port == PIW'(i)) begin
        w_joy_sel  = i_joy[16*i +: 16];
        w_conn_sel = i_pconn[i];
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (r_sidx == 4'(i)) w_stat_byte = i_stat[127-8*i -: 8];
    end
  end

  // Free space left in the current fragment and size of the next record.
  assign w_space = r_full ? '0 : ((AW+1)'(OREG_DEPTH) - (AW+1)'(r_ptr));
  assign w_need  = w_conn_sel ? (AW+1)'(4) : (AW+1)'(1);

  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_full_nx    = r_full;
    w_sidx_nx    = r_sidx;
    w_port_nx    = r_port;
    w_byte_nx    = r_byte;
    w_joy_nx     = r_joy;
    w_preq_nx    = r_preq;
    w_pend_nx    = r_pend;
    w_irq_cnt_nx = r_irq_cnt;
    w_we_nx      = 1'b0;
    w_addr_nx    = r_oreg_addr;
    w_data_nx    = r_oreg_data;
    w_sr_hi_nx   = r_sr_hi;
    w_sf_clr_nx  = 1'b0;
    w_mirq_n_nx  = r_mirq_n;
    w_busy_nx    = r_busy;
    w_wr         = 1'b0;
    w_wr_byte    = 8'h00;
    w_port_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_busy_nx = 1'b1;
          w_ptr_nx  = '0;
          w_full_nx = 1'b0;
          w_port_nx = '0;
          w_byte_nx = 2'd0;
          w_sidx_nx = 4'd0;
          w_pend_nx = 1'b0;
          w_preq_nx = i_ireg1[3];
          if (i_ireg0[0])      w_state_nx = S_STATUS;
          else if (i_ireg1[3]) w_state_nx = S_PERIPH;
          else                 w_state_nx = S_DONE;
        end
      end
      S_STATUS: begin
        if (i_ce) begin
          w_wr      = 1'b1;
          w_wr_byte = w_stat_byte;
          w_sidx_nx = r_sidx + 4'd1;
          if (r_sidx == 4'd15) begin
            w_sr_hi_nx = {2'b01, r_preq};
            w_pend_nx  = r_preq;
            w_state_nx = S_PAD;
          end
        end
      end
      S_PERIPH: begin
        if (i_ce) begin
          if (r_byte == 2'd0) begin
            // A record that does not fit closes this fragment untouched.
            if (w_space < w_need) begin
              w_sr_hi_nx = 3'b111;
              w_state_nx = S_PAD;
            end else begin
              w_joy_nx  = w_joy_sel;
              w_wr      = 1'b1;
              w_wr_byte = w_conn_sel ? 8'hF1 : 8'hF0;
              if (w_conn_sel) w_byte_nx = 2'd1;
              else            w_port_done = 1'b1;
            end
          end else begin
            w_wr = 1'b1;
            case (r_byte)
              2'd1:    w_wr_byte = 8'h02;
              2'd2:    w_wr_byte = r_joy[15:8];
              default: w_wr_byte = r_joy[7:0];
            endcase
            if (r_byte == 2'd3) w_port_done = 1'b1;
            else                w_byte_nx = r_byte + 2'd1;
          end
          if (w_port_done) begin
            w_byte_nx = 2'd0;
            if (r_port == PIW'(NUM_PORTS - 1)) begin
              w_sr_hi_nx = 3'b110;
              w_state_nx = S_PAD;
            end else begin
              w_port_nx = r_port + PIW'(1);
            end
          end
        end
      end
`ifdef SMPC_OREG_PAD_EN
      S_PAD: begin
        if (i_ce) begin
          if (r_full) begin
            w_state_nx = S_IRQ;
          end else begin
            w_wr      = 1'b1;
            w_wr_byte = 8'h00;
            if (r_ptr == AW'(OREG_DEPTH - 1)) w_state_nx = S_IRQ;
          end
        end
      end
`else
      S_PAD: w_state_nx = S_IRQ;
`endif
      S_IRQ: begin
        if (i_ce) begin
          if (r_irq_cnt < CW'(IRQ_CYCLES)) begin
            w_mirq_n_nx  = 1'b0;
            w_irq_cnt_nx = r_irq_cnt + CW'(1);
          end else begin
            w_mirq_n_nx  = 1'b1;
            w_irq_cnt_nx = '0;
            w_state_nx   = (r_sr_hi[0] || r_pend) ? S_WAIT_HS : S_DONE;
          end
        end
      end
      S_WAIT_HS: begin
        if (i_brk) begin
          w_sr_hi_nx = 3'b000;
          w_state_nx = S_DONE;
        end else if (i_cont) begin
          w_ptr_nx   = '0;
          w_full_nx  = 1'b0;
          w_pend_nx  = 1'b0;
          w_byte_nx  = 2'd0;
          w_state_nx = S_PERIPH;
        end
      end
      S_DONE: begin
        if (i_ce) begin
          w_sf_clr_nx = 1'b1;
          w_busy_nx   = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Saturating write pointer: once the last address is written, further writes are dropped.
    if (w_wr && !r_full) begin
      w_we_nx   = 1'b1;
      w_addr_nx = r_ptr;
      w_data_nx = w_wr_byte;
      if (r_ptr == AW'(OREG_DEPTH - 1)) w_full_nx = 1'b1;
      else                              w_ptr_nx  = r_ptr + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_full      <= 1'b0;
      r_sidx      <= 4'd0;
      r_port      <= '0;
      r_byte      <= 2'd0;
      r_joy       <= 16'h0000;
      r_preq      <= 1'b0;
      r_pend      <= 1'b0;
      r_irq_cnt   <= '0;
      r_oreg_we   <= 1'b0;
      r_oreg_addr <= '0;
      r_oreg_data <= 8'h00;
      r_sr_hi     <= 3'b000;
      r_sf_clr    <= 1'b0;
      r_mirq_n    <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_full      <= w_full_nx;
      r_sidx      <= w_sidx_nx;
      r_port      <= w_port_nx;
      r_byte      <= w_byte_nx;
      r_joy       <= w_joy_nx;
      r_preq      <= w_preq_nx;
      r_pend      <= w_pend_nx;
      r_irq_cnt   <= w_irq_cnt_nx;
      r_oreg_we   <= w_we_nx;
      r_oreg_addr <= w_addr_nx;
      r_oreg_data <= w_data_nx;
      r_sr_hi     <= w_sr_hi_nx;
      r_sf_clr    <= w_sf_clr_nx;
      r_mirq_n    <= w_mirq_n_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign o_oreg_we   = r_oreg_we;
  assign o_oreg_addr = r_oreg_addr;
  assign o_oreg_data = r_oreg_data;
  assign o_sr_hi     = r_sr_hi;
  assign o_sf_clr    = r_sf_clr;
  assign o_mirq_n    = r_mirq_n;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_smpc_intback_engine.sv
// Directed bench for smpc_intback_engine: three instances (2 ports/32, 8 ports/8, 1 port/32).
// Expectations follow SMPC_OREG_PAD_EN when it is defined for the build.
module tb_smpc_intback_engine;
`ifdef SMPC_OREG_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b1;
  logic [7:0]   ireg0 = 8'h00;
  logic [7:0]   ireg1 = 8'h00;
  logic [127:0] stat = '0;
  logic         cont = 1'b0;
  logic         brk = 1'b0;
  logic         start [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0]   pconn_a = '0;
  logic [31:0]  joy_a = '0;
  logic [7:0]   pconn_b = '0;
  logic [127:0] joy_b = '0;
  logic [0:0]   pconn_c = '0;
  logic [15:0]  joy_c = '0;

  logic         we [3];
  logic [7:0]   data [3];
  logic [2:0]   sr [3];
  logic         sf [3];
  logic         mirq [3];
  logic         busy [3];
  logic [4:0]   a_addr;
  logic [2:0]   b_addr;
  logic [4:0]   c_addr;
  logic [7:0]   addr [3];

  assign addr[0] = {3'b000, a_addr};
  assign addr[1] = {5'b00000, b_addr};
  assign addr[2] = {3'b000, c_addr};

  always #5 clk = ~clk;

  smpc_intback_engine #(.NUM_PORTS(2), .OREG_DEPTH(32), .IRQ_CYCLES(4)) u_a (
    .CLK(clk), .RST_N(rst_n), .i_ce(ce), .i_start(start[0]), .i_ireg0(ireg0), .i_ireg1(ireg1),
    .i_stat(stat), .i_cont(cont), .i_brk(brk), .i_pconn(pconn_a), .i_joy(joy_a),
    .o_oreg_we(we[0]), .o_oreg_addr(a_addr), .o_oreg_data(data[0]), .o_sr_hi(sr[0]),
    .o_sf_clr(sf[0]), .o_mirq_n(mirq[0]), .o_busy(busy[0]));

  smpc_intback_engine #(.NUM_PORTS(8), .OREG_DEPTH(8), .IRQ_CYCLES(4)) u_b (
    .CLK(clk), .RST_N(rst_n), .i_ce(ce), .i_start(start[1]), .i_ireg0(ireg0), .i_ireg1(ireg1),
    .i_stat(stat), .i_cont(cont), .i_brk(brk), .i_pconn(pconn_b), .i_joy(joy_b),
    .o_oreg_we(we[1]), .o_oreg_addr(b_addr), .o_oreg_data(data[1]), .o_sr_hi(sr[1]),
    .o_sf_clr(sf[1]), .o_mirq_n(mirq[1]), .o_busy(busy[1]));

  smpc_intback_engine #(.NUM_PORTS(1), .OREG_DEPTH(32), .IRQ_CYCLES(4)) u_c (
    .CLK(clk), .RST_N(rst_n), .i_ce(ce), .i_start(start[2]), .i_ireg0(ireg0), .i_ireg1(ireg1),
    .i_stat(stat), .i_cont(cont), .i_brk(brk), .i_pconn(pconn_c), .i_joy(joy_c),
    .o_oreg_we(we[2]), .o_oreg_addr(c_addr), .o_oreg_data(data[2]), .o_sr_hi(sr[2]),
    .o_sf_clr(sf[2]), .o_mirq_n(mirq[2]), .o_busy(busy[2]));

  // Write log and event counters per instance, sampled just after each rising edge.
  int          wcnt [3]  = '{0, 0, 0};
  int          lo [3]    = '{0, 0, 0};
  int          falls [3] = '{0, 0, 0};
  int          sfc [3]   = '{0, 0, 0};
  logic        mirq_q [3] = '{1'b1, 1'b1, 1'b1};
  logic [15:0] wlog [3][256];

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (we[d] === 1'b1) begin
        if (wcnt[d] < 256) wlog[d][wcnt[d]] = {addr[d], data[d]};
        wcnt[d]++;
      end
      if (mirq[d] === 1'b0) lo[d]++;
      if (mirq[d] === 1'b0 && mirq_q[d] === 1'b1) falls[d]++;
      if (sf[d] === 1'b1) sfc[d]++;
      mirq_q[d] = mirq[d];
    end
  end

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] eb [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic reached(input int d, input int what);
    case (what)
      0:       return (mirq[d] === 1'b0);
      1:       return (mirq[d] === 1'b1);
      default: return (busy[d] === 1'b0);
    endcase
  endfunction

  // what: 0 = MIRQ_N low, 1 = MIRQ_N high, 2 = BUSY low
  task automatic wait_for(input int d, input int what, input string tag);
    int n = 0;
    while (n < 2000 && !reached(d, what)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reached"}, 32'(reached(d, what)), 32'd1);
  endtask

  task automatic set_eb8(input logic [63:0] v);
    for (int k = 0; k < 8; k++) eb[k] = v[63-8*k -: 8];
  endtask

  // Fragment = n data bytes from eb at 0..n-1, plus zero fill to depth when padding is built in.
  task automatic check_frag(input int d, input int base, input int n, input int depth, input string tag);
    int   exp_n;
    logic ok;
    exp_n = PAD_EN ? depth : n;
    chk({tag, "_count"}, 32'(wcnt[d] - base), 32'(exp_n));
    ok = 1'b1;
    for (int k = 0; k < exp_n; k++) begin
      if (base + k < 256) begin
        if (wlog[d][base+k] !== {8'(k), (k < n) ? eb[k] : 8'h00}) ok = 1'b0;
      end
    end
    chk({tag, "_bytes"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int b, lb, fb, sb;

    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we[0]), 32'd0);
    chk("rst_addr", 32'(addr[0]), 32'd0);
    chk("rst_data", 32'(data[0]), 32'd0);
    chk("rst_sr", 32'(sr[0]), 32'd0);
    chk("rst_sfclr", 32'(sf[0]), 32'd0);
    chk("rst_mirq", 32'(mirq[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_bc", 32'({busy[1], busy[2], mirq[1], mirq[2]}), 32'b0011);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Status + peripheral request, both ports connected.
    stat    = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    pconn_a = 2'b11;
    joy_a   = {16'h1234, 16'hFFF7};
    ireg0   = 8'h01;
    ireg1   = 8'h08;
    b = wcnt[0]; lb = lo[0]; fb = falls[0]; sb = sfc[0];
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    chk("t1_busy_set", 32'(busy[0]), 32'd1);
    chk("t1_no_we_yet", 32'(we[0]), 32'd0);
    @(negedge clk);
    chk("t1_first_we", 32'(we[0]), 32'd1);
    chk("t1_first_addr", 32'(addr[0]), 32'd0);
    chk("t1_first_data", 32'(data[0]), 32'hA0);
    wait_for(0, 0, "t1_irq1");
    for (int k = 0; k < 16; k++) eb[k] = 8'(8'hA0 + k);
    check_frag(0, b, 16, 32, "t1_frag1");
    chk("t1_sr1", 32'(sr[0]), 32'b011);
    wait_for(0, 1, "t1_irq1_end");
    chk("t1_irq1_len", 32'(lo[0] - lb), 32'd4);
    b = wcnt[0];
    repeat (6) @(negedge clk);
    chk("t1_hold_busy", 32'(busy[0]), 32'd1);
    chk("t1_hold_nowr", 32'(wcnt[0] - b), 32'd0);
    lb = lo[0];
    cont = 1'b1; @(negedge clk); cont = 1'b0;
    wait_for(0, 2, "t1_done");
    set_eb8(64'hF102FFF7_F1021234);
    check_frag(0, b, 8, 32, "t1_frag2");
    chk("t1_sr2", 32'(sr[0]), 32'b110);
    chk("t1_irq2_len", 32'(lo[0] - lb), 32'd4);
    chk("t1_irqs", 32'(falls[0] - fb), 32'd2);
    chk("t1_sfclr", 32'(sfc[0] - sb), 32'd1);
    repeat (2) @(negedge clk);

    // Peripheral only, port 1 unconnected; a second START while busy is ignored.
    pconn_a = 2'b01;
    joy_a   = {16'h5555, 16'h8421};
    ireg0   = 8'h00;
    ireg1   = 8'h08;
    b = wcnt[0]; fb = falls[0]; sb = sfc[0];
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_for(0, 2, "t2_done");
    eb[0] = 8'hF1; eb[1] = 8'h02; eb[2] = 8'h84; eb[3] = 8'h21; eb[4] = 8'hF0;
    check_frag(0, b, 5, 32, "t2_frag");
    chk("t2_sr", 32'(sr[0]), 32'b110);
    chk("t2_irqs", 32'(falls[0] - fb), 32'd1);
    chk("t2_sfclr", 32'(sfc[0] - sb), 32'd1);
    repeat (2) @(negedge clk);

    // 8 connected ports into an 8-byte OREG: four fragments.
    pconn_b = 8'hFF;
    for (int i = 0; i < 8; i++) joy_b[16*i +: 16] = {8'(8'h10 + i), 8'(8'h80 + i)};
    b = wcnt[1]; sb = sfc[1]; fb = falls[1];
    start[1] = 1'b1; @(negedge clk); start[1] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_for(1, 0, $sformatf("t3_irq%0d", f));
      eb[0] = 8'hF1; eb[1] = 8'h02; eb[2] = 8'(8'h10 + 2*f); eb[3] = 8'(8'h80 + 2*f);
      eb[4] = 8'hF1; eb[5] = 8'h02; eb[6] = 8'(8'h11 + 2*f); eb[7] = 8'(8'h81 + 2*f);
      check_frag(1, b, 8, 8, $sformatf("t3_frag%0d", f));
      chk($sformatf("t3_sr%0d", f), 32'(sr[1]), (f < 3) ? 32'b111 : 32'b110);
      wait_for(1, 1, $sformatf("t3_irq%0d_end", f));
      if (f < 3) begin
        b = wcnt[1];
        cont = 1'b1; @(negedge clk); cont = 1'b0;
      end
    end
    wait_for(1, 2, "t3_done");
    chk("t3_irqs", 32'(falls[1] - fb), 32'd4);
    chk("t3_sfclr", 32'(sfc[1] - sb), 32'd1);
    repeat (2) @(negedge clk);

    // BRK outside WAIT_HS is ignored; BRK with CONT in WAIT_HS aborts.
    pconn_a = 2'b11;
    joy_a   = {16'h1234, 16'hFFF7};
    ireg0   = 8'h01;
    ireg1   = 8'h08;
    b = wcnt[0]; sb = sfc[0];
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (2) @(negedge clk);
    brk = 1'b1; @(negedge clk); brk = 1'b0;
    wait_for(0, 0, "t4_irq");
    for (int k = 0; k < 16; k++) eb[k] = 8'(8'hA0 + k);
    check_frag(0, b, 16, 32, "t4_frag1");
    chk("t4_sr1", 32'(sr[0]), 32'b011);
    wait_for(0, 1, "t4_irq_end");
    b = wcnt[0];
    cont = 1'b1; brk = 1'b1; @(negedge clk); cont = 1'b0; brk = 1'b0;
    wait_for(0, 2, "t4_done");
    repeat (4) @(negedge clk);
    chk("t4_sr", 32'(sr[0]), 32'b000);
    chk("t4_nowr", 32'(wcnt[0] - b), 32'd0);
    chk("t4_sfclr", 32'(sfc[0] - sb), 32'd1);
    chk("t4_busy", 32'(busy[0]), 32'd0);

    // Single unconnected port.
    pconn_c = 1'b0;
    ireg0   = 8'h00;
    ireg1   = 8'h08;
    b = wcnt[2]; sb = sfc[2];
    start[2] = 1'b1; @(negedge clk); start[2] = 1'b0;
    wait_for(2, 0, "t5_irq");
    eb[0] = 8'hF0;
    check_frag(2, b, 1, 32, "t5_frag");
    chk("t5_sr", 32'(sr[2]), 32'b110);
    wait_for(2, 2, "t5_done");
    chk("t5_sfclr", 32'(sfc[2] - sb), 32'd1);
    chk("t5_total", 32'(wcnt[2] - b), PAD_EN ? 32'd32 : 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of PERIPH, then a clean rerun.
    pconn_a = 2'b11;
    ireg0   = 8'h00;
    ireg1   = 8'h08;
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 32'({we[0], addr[0], data[0], sr[0], sf[0], mirq[0], busy[0]}), 32'b10);
    b = wcnt[0];
    repeat (3) @(negedge clk);
    chk("t6_rst_nowr", 32'(wcnt[0] - b), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = wcnt[0]; fb = falls[0]; sb = sfc[0];
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_for(0, 2, "t6_done");
    set_eb8(64'hF102FFF7_F1021234);
    check_frag(0, b, 8, 32, "t6_frag");
    chk("t6_sr", 32'(sr[0]), 32'b110);
    chk("t6_irqs", 32'(falls[0] - fb), 32'd1);
    chk("t6_sfclr", 32'(sfc[0] - sb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
